// File: rtl/rom_fetch_arbiter.sv
// rtl/rom_fetch_arbiter.sv - two-port arbiter sequencing byte reads from the boot ROM
//
// Shares the byte-wide boot ROM read port between the instruction-fetch (I)
// and data-load (D) requesters. A granted request is checked for size,
// alignment and range, then its bytes are read one per cycle and assembled
// big-endian. The result is returned with a one-cycle acknowledge.
//
// Ports:
//   clk        system clock, all logic on posedge
//   nReset     synchronous active-low reset
//   iReq       fetch request (level, held until iAck)
//   iAddr      fetch byte address
//   iAck       fetch completion pulse
//   iData      fetched word, held until the next iAck
//   iErr       fetch error, qualified by iAck
//   dReq       load request (level, held until dAck)
//   dAddr      load byte address
//   dSize      load size: 0=byte 1=half 2=word 3=illegal
//   dAck       load completion pulse
//   dData      load result, zero-extended and right-aligned, held until next dAck
//   dErr       load error, qualified by dAck
//   romSelect  registered byte address to the ROM
//   romData    ROM byte output
module rom_fetch_arbiter #(
  parameter int SELECT_WIDTH = 32,
  parameter int MEMORY_SIZE  = 128,
  parameter int ROM_LATENCY  = 1
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    iReq,
  input  logic [SELECT_WIDTH-1:0] iAddr,
  output logic                    iAck,
  output logic [31:0]             iData,
  output logic                    iErr,
  input  logic                    dReq,
  input  logic [SELECT_WIDTH-1:0] dAddr,
  input  logic [1:0]              dSize,
  output logic                    dAck,
  output logic [31:0]             dData,
  output logic                    dErr,
  output logic [SELECT_WIDTH-1:0] romSelect,
  input  logic [7:0]              romData
);

  localparam int SW = SELECT_WIDTH;
  // The ROM samples romSelect one edge after it is driven, then needs
  // ROM_LATENCY more edges, so the first capture lands ROM_LATENCY+1 edges in.
  localparam logic [3:0] LAT     = 4'(ROM_LATENCY);
  localparam logic [3:0] LAT1    = 4'(ROM_LATENCY + 1);
  localparam logic [SW:0] MEM_LIM = (SW+1)'(MEMORY_SIZE);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   addr_q, addr_d;
  logic [2:0]      n_q, n_d;
  logic            gnt_i_q, gnt_i_d;
  logic            last_d_q, last_d_d;
  logic [3:0]      cyc_q, cyc_d;
  logic [31:0]     shift_q, shift_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            iack_q, iack_d, ierr_q, ierr_d;
  logic            dack_q, dack_d, derr_q, derr_d;
  logic [31:0]     idata_q, idata_d, ddata_q, ddata_d;

  logic            take_i;
  logic [SW-1:0]   req_addr;
  logic [2:0]      req_n;
  logic            req_err;
  logic [SW:0]     end_addr;
  logic [3:0]      edge_k;
  logic [31:0]     shifted;

  // Round-robin: on a tie, grant the port that did not win last time.
  assign take_i   = iReq && (!dReq || last_d_q);
  assign req_addr = take_i ? iAddr : dAddr;

  always_comb begin
    req_n = 3'd4;
    if (!take_i) begin
      case (dSize)
        2'd0:    req_n = 3'd1;
        2'd1:    req_n = 3'd2;
        default: req_n = 3'd4;
      endcase
    end
  end

  // One extra bit so an address near the top of the space cannot wrap past the limit.
  assign end_addr = {1'b0, req_addr} + {{(SW-2){1'b0}}, req_n};

  assign req_err = (!take_i && dSize == 2'd3)
                || (req_n == 3'd2 && req_addr[0])
                || (req_n == 3'd4 && req_addr[1:0] != 2'b00)
                || (end_addr > MEM_LIM);

  assign edge_k  = cyc_q + 4'd1;
  assign shifted = {shift_q[23:0], romData};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    n_d      = n_q;
    gnt_i_d  = gnt_i_q;
    last_d_d = last_d_q;
    cyc_d    = cyc_q;
    shift_d  = shift_q;
    sel_d    = sel_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    idata_d  = idata_q;
    ierr_d   = ierr_q;
    ddata_d  = ddata_q;
    derr_d   = derr_q;
    case (state_q)
      IDLE: begin
        if (iReq || dReq) begin
          gnt_i_d  = take_i;
          last_d_d = !take_i;
          addr_d   = req_addr;
          n_d      = req_n;
          cyc_d    = 4'd0;
          shift_d  = 32'd0;
          if (req_err) begin
            state_d = RESP;
            if (take_i) begin
              iack_d  = 1'b1;
              idata_d = 32'd0;
              ierr_d  = 1'b1;
            end else begin
              dack_d  = 1'b1;
              ddata_d = 32'd0;
              derr_d  = 1'b1;
            end
          end else begin
            sel_d   = req_addr;
            state_d = READ;
          end
        end
      end
      READ: begin
        cyc_d = edge_k;
        // Issue side: present addr+k for k<n, then hold the last address.
        if (edge_k < {1'b0, n_q}) sel_d = addr_q + SW'(edge_k);
        // Capture side trails the issue side by the fixed ROM delay.
        if (edge_k >= LAT1) shift_d = shifted;
        if (edge_k == {1'b0, n_q} + LAT) begin
          state_d = RESP;
          if (gnt_i_q) begin
            iack_d  = 1'b1;
            idata_d = shifted;
            ierr_d  = 1'b0;
          end else begin
            dack_d  = 1'b1;
            ddata_d = shifted;
            derr_d  = 1'b0;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      n_q      <= 3'd0;
      gnt_i_q  <= 1'b0;
      last_d_q <= 1'b1;
      cyc_q    <= 4'd0;
      shift_q  <= 32'd0;
      sel_q    <= '0;
      iack_q   <= 1'b0;
      ierr_q   <= 1'b0;
      idata_q  <= 32'd0;
      dack_q   <= 1'b0;
      derr_q   <= 1'b0;
      ddata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      n_q      <= n_d;
      gnt_i_q  <= gnt_i_d;
      last_d_q <= last_d_d;
      cyc_q    <= cyc_d;
      shift_q  <= shift_d;
      sel_q    <= sel_d;
      iack_q   <= iack_d;
      ierr_q   <= ierr_d;
      idata_q  <= idata_d;
      dack_q   <= dack_d;
      derr_q   <= derr_d;
      ddata_q  <= ddata_d;
    end
  end

  assign iAck      = iack_q;
  assign iData     = idata_q;
  assign iErr      = ierr_q;
  assign dAck      = dack_q;
  assign dData     = ddata_q;
  assign dErr      = derr_q;
  assign romSelect = sel_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb/tb_rom_fetch_arbiter.sv - directed self-checking bench for rom_fetch_arbiter
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        nReset;
  logic        iReq, dReq;
  logic [31:0] iAddr, dAddr;
  logic [1:0]  dSize;
  logic        iAck, iErr, dAck, dErr;
  logic [31:0] iData, dData, romSelect;
  logic [7:0]  romData;

  logic [7:0]  rom [0:127];
  logic [7:0]  rom_q;
  logic [31:0] sel_hist [0:31];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of latency.
  always @(posedge clk) rom_q <= rom[romSelect[6:0]];
  assign romData = rom_q;

  rom_fetch_arbiter #(.SELECT_WIDTH(32), .MEMORY_SIZE(128), .ROM_LATENCY(1)) dut (
    .clk(clk), .nReset(nReset),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iData(iData), .iErr(iErr),
    .dReq(dReq), .dAddr(dAddr), .dSize(dSize), .dAck(dAck), .dData(dData), .dErr(dErr),
    .romSelect(romSelect), .romData(romData)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Single request; caller guarantees the DUT is IDLE at the next edge.
  task automatic xfer(input string tag, input bit use_i, input logic [31:0] addr,
                      input logic [1:0] size, input int exp_cyc,
                      input logic [31:0] exp_data, input logic exp_err);
    int          cyc;
    bit          seen;
    logic [31:0] sel_before, other_before;
    sel_before   = romSelect;
    other_before = use_i ? dData : iData;
    if (use_i) begin iReq = 1'b1; iAddr = addr; end
    else begin dReq = 1'b1; dAddr = addr; dSize = size; end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      sel_hist[cyc-1] = romSelect;
      seen = use_i ? iAck : dAck;
    end
    check({tag, "_cyc"}, seen ? cyc : -1, exp_cyc);
    check({tag, "_data"}, use_i ? iData : dData, exp_data);
    check({tag, "_err"}, {31'd0, use_i ? iErr : dErr}, {31'd0, exp_err});
    check({tag, "_other"}, use_i ? dData : iData, other_before);
    if (exp_err) check({tag, "_sel"}, romSelect, sel_before);
    iReq = 1'b0;
    dReq = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int   cyc;
    int   nev, ni, nd;
    int   ev_cyc [0:3];
    bit   ev_i   [0:3];
    logic [31:0] ev_data [0:3];
    bit   seen;

    rom[0] = 8'h3C; rom[1] = 8'h08; rom[2] = 8'h00; rom[3] = 8'h10;
    for (int a = 4; a < 128; a++) rom[a] = 8'(a) ^ 8'hA5;

    nReset = 1'b0; iReq = 1'b0; dReq = 1'b0;
    iAddr = 32'd0; dAddr = 32'd0; dSize = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_iack", {31'd0, iAck}, 32'd0);
    check("rst_dack", {31'd0, dAck}, 32'd0);
    check("rst_errs", {30'd0, iErr, dErr}, 32'd0);
    check("rst_idata", iData, 32'd0);
    check("rst_ddata", dData, 32'd0);
    check("rst_sel", romSelect, 32'd0);
    nReset = 1'b1;

    // Arbitration: both held; alternation I, D, I, D starting with I after reset.
    iReq = 1'b1; iAddr = 32'd0;
    dReq = 1'b1; dAddr = 32'd8; dSize = 2'd1;
    cyc = 0; nev = 0; ni = 0; nd = 0;
    while (nev < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (iAck) begin
        ev_cyc[nev] = cyc; ev_i[nev] = 1'b1; ev_data[nev] = iData; nev++; ni++;
        if (ni == 2) iReq = 1'b0;
      end
      if (dAck && nev < 4) begin
        ev_cyc[nev] = cyc; ev_i[nev] = 1'b0; ev_data[nev] = dData; nev++; nd++;
        if (nd == 2) dReq = 1'b0;
      end
    end
    check("arb_nev", nev, 4);
    if (nev == 4) begin
      check("arb0_port", {31'd0, ev_i[0]}, 32'd1);
      check("arb0_cyc", ev_cyc[0], 6);
      check("arb0_data", ev_data[0], 32'h3C080010);
      check("arb1_port", {31'd0, ev_i[1]}, 32'd0);
      check("arb1_cyc", ev_cyc[1], 11);
      check("arb1_data", ev_data[1], 32'h0000ADAC);
      check("arb2_port", {31'd0, ev_i[2]}, 32'd1);
      check("arb2_cyc", ev_cyc[2], 18);
      check("arb3_port", {31'd0, ev_i[3]}, 32'd0);
      check("arb3_cyc", ev_cyc[3], 23);
    end
    iReq = 1'b0; dReq = 1'b0;
    @(posedge clk); #1;

    // Word fetch and the romSelect walk.
    xfer("word0", 1'b1, 32'd0, 2'd0, 6, 32'h3C080010, 1'b0);
    check("walk0", sel_hist[0], 32'd0);
    check("walk1", sel_hist[1], 32'd1);
    check("walk2", sel_hist[2], 32'd2);
    check("walk3", sel_hist[3], 32'd3);
    check("walk4", sel_hist[4], 32'd3);

    // Data sizes.
    xfer("dbyte2", 1'b0, 32'd2, 2'd0, 3, 32'h00000000, 1'b0);
    xfer("dhalf2", 1'b0, 32'd2, 2'd1, 4, 32'h00000010, 1'b0);
    xfer("dbyte3", 1'b0, 32'd3, 2'd0, 3, 32'h00000010, 1'b0);
    xfer("dword4", 1'b0, 32'd4, 2'd2, 6, 32'hA1A0A3A2, 1'b0);

    // Reset in the middle of an I fetch.
    iReq = 1'b1; iAddr = 32'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nReset = 1'b0; iReq = 1'b0;
    @(posedge clk); #1;
    check("mid_iack", {31'd0, iAck}, 32'd0);
    check("mid_idata", iData, 32'd0);
    check("mid_ddata", dData, 32'd0);
    check("mid_sel", romSelect, 32'd0);
    nReset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (iAck) seen = 1'b1;
    end
    check("mid_noack", {31'd0, seen}, 32'd0);
    xfer("fresh", 1'b1, 32'd4, 2'd0, 6, 32'hA1A0A3A2, 1'b0);

    // Rejected requests.
    xfer("err_w1", 1'b0, 32'd1, 2'd2, 1, 32'd0, 1'b1);
    xfer("err_h3", 1'b0, 32'd3, 2'd1, 1, 32'd0, 1'b1);
    xfer("err_sz", 1'b0, 32'd0, 2'd3, 1, 32'd0, 1'b1);
    xfer("err_i126", 1'b1, 32'd126, 2'd0, 1, 32'd0, 1'b1);
    xfer("err_rng", 1'b0, 32'd127, 2'd1, 1, 32'd0, 1'b1);
    xfer("err_wrap", 1'b1, 32'hFFFFFFFC, 2'd0, 1, 32'd0, 1'b1);
    xfer("top_byte", 1'b0, 32'd127, 2'd0, 3, 32'h000000DA, 1'b0);

    // Back-to-back fetches with iReq held; dData must not move.
    xfer("d_pre", 1'b0, 32'd8, 2'd1, 4, 32'h0000ADAC, 1'b0);
    iReq = 1'b1; iAddr = 32'd0;
    cyc = 0; ni = 0; seen = 1'b0;
    while (ni < 2 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (dAck) seen = 1'b1;
      if (iAck) begin
        ev_cyc[ni] = cyc; ev_data[ni] = iData; ni++;
        if (ni == 1) iAddr = 32'd4;
        else iReq = 1'b0;
      end
    end
    iReq = 1'b0;
    check("b2b_n", ni, 2);
    if (ni == 2) begin
      check("b2b0_cyc", ev_cyc[0], 6);
      check("b2b0_data", ev_data[0], 32'h3C080010);
      check("b2b1_cyc", ev_cyc[1], 13);
      check("b2b1_data", ev_data[1], 32'hA1A0A3A2);
    end
    check("b2b_nodack", {31'd0, seen}, 32'd0);
    check("b2b_ddata", dData, 32'h0000ADAC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
